// File: rtl/snake_pkg.sv
// Shared types for the snake game and its 8x8 LED matrix driver.
// Frame bit r*COLS+c is row r, column c.
package snake_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef logic [ROWS*COLS-1:0] frame_t;

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } scan_st_e;

  function automatic logic [5:0] bit_idx(
    input logic [2:0] r,
    input logic [2:0] c
  );
    return 6'(int'(r) * COLS + int'(c));
  endfunction

endpackage

// File: rtl/frame_buffer.sv
// Pending/active double buffer for matrix_scan: accepts one frame
// per handshake and promotes it to active at the frame boundary.
module frame_buffer
  import snake_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  frame_t frame_i,
  input  logic   valid_i,
  output logic   ready_o,
  input  logic   swap_i,
  output frame_t active_nxt_o,
  output logic   swapped_o
);

  frame_t active_q;
  frame_t pending_q;
  logic   full_q;
  logic   swapped_q;
  logic   take;
  logic   load;

  assign ready_o   = !full_q;
  assign take      = valid_i && !full_q;
  assign load      = swap_i && full_q;
  assign swapped_o = swapped_q;

  // Row data is registered from the post-swap image so the new
  // frame lands on the same edge that starts row 0.
  assign active_nxt_o = load ? pending_q : active_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q  <= '0;
      pending_q <= '0;
      full_q    <= 1'b0;
      swapped_q <= 1'b0;
    end else begin
      swapped_q <= load;
      if (take) begin
        pending_q <= frame_i;
        full_q    <= 1'b1;
      end
      if (load) begin
        active_q <= pending_q;
        full_q   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/matrix_scan.sv
// Row-multiplexing driver for the 8x8 LED matrix.
// SCAN_BLANK_EN inserts BLANK dead cycles before every row.
module matrix_scan
  import snake_pkg::*;
#(
  parameter int unsigned DWELL = 1000,
  parameter int unsigned BLANK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  frame_t          frame,
  input  logic            frame_valid,
  output logic            frame_ready,
  output logic [ROWS-1:0] row_en,
  output logic [COLS-1:0] col_data,
  output logic            frame_start,
  output logic            swapped
);

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  scan_st_e        st_q, st_d;
  logic [2:0]      row_q, row_d;
  logic [15:0]     dwell_q, dwell_d;
  logic            enter;
  logic            boundary;
  logic            drive_d;
  frame_t          active_nxt;
  logic [ROWS-1:0] row_en_q, row_en_d;
  logic [COLS-1:0] col_q, col_d;
  logic            fs_q, fs_d;

`ifdef SCAN_BLANK_EN
  localparam logic [7:0] BLANK_LAST = 8'(BLANK - 1);
  localparam scan_st_e   ST_RST     = ST_BLANK;
  logic [7:0] blank_q, blank_d;
`else
  localparam scan_st_e   ST_RST     = ST_DRIVE;
  logic run_q, run_d;
`endif

  frame_buffer u_buf (
    .clk_i       (clk),
    .rst_ni      (reset),
    .frame_i     (frame),
    .valid_i     (frame_valid),
    .ready_o     (frame_ready),
    .swap_i      (boundary),
    .active_nxt_o(active_nxt),
    .swapped_o   (swapped)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q    <= ST_RST;
      row_q   <= '0;
      dwell_q <= '0;
`ifdef SCAN_BLANK_EN
      blank_q <= '0;
`else
      run_q   <= 1'b0;
`endif
    end else begin
      st_q    <= st_d;
      row_q   <= row_d;
      dwell_q <= dwell_d;
`ifdef SCAN_BLANK_EN
      blank_q <= blank_d;
`else
      run_q   <= run_d;
`endif
    end
  end

  always_comb begin
    st_d     = st_q;
    row_d    = row_q;
    dwell_d  = dwell_q;
    enter    = 1'b0;
    boundary = 1'b0;
`ifdef SCAN_BLANK_EN
    blank_d  = blank_q;
    unique case (st_q)
      ST_BLANK: begin
        if (blank_q == BLANK_LAST) begin
          blank_d = '0;
          st_d    = ST_DRIVE;
          enter   = 1'b1;
        end else begin
          blank_d = blank_q + 8'd1;
        end
      end
      ST_DRIVE: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d  = '0;
          row_d    = row_q + 3'd1;
          st_d     = ST_BLANK;
          boundary = (row_q == 3'(ROWS - 1));
        end else begin
          dwell_d = dwell_q + 16'd1;
        end
      end
      default: st_d = ST_BLANK;
    endcase
    drive_d = (st_d == ST_DRIVE);
`else
    run_d    = 1'b1;
    // First cycle out of reset shows nothing; row 0 starts next.
    unique case (st_q)
      ST_DRIVE: begin
        if (!run_q) begin
          enter = 1'b1;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d  = '0;
          row_d    = row_q + 3'd1;
          enter    = 1'b1;
          boundary = (row_q == 3'(ROWS - 1));
        end else begin
          dwell_d = dwell_q + 16'd1;
        end
      end
      default: st_d = ST_DRIVE;
    endcase
    drive_d = run_d;
`endif
  end

  always_comb begin
    row_en_d = '0;
    col_d    = '0;
    fs_d     = enter && (row_d == 3'd0);
    if (drive_d) begin
      row_en_d[row_d] = 1'b1;
      col_d = active_nxt[bit_idx(row_d, 3'd0) +: COLS];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_en_q <= '0;
      col_q    <= '0;
      fs_q     <= 1'b0;
    end else begin
      row_en_q <= row_en_d;
      col_q    <= col_d;
      fs_q     <= fs_d;
    end
  end

  assign row_en      = row_en_q;
  assign col_data    = col_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_matrix_scan.sv
// Self-checking bench for matrix_scan (DWELL=4, BLANK=2) plus a
// DWELL=1 instance checked for row order and frame_start period.
module tb_matrix_scan;
  import snake_pkg::*;

  localparam int D = 4;
  localparam int B = 2;
`ifdef SCAN_BLANK_EN
  localparam int L  = D + B;
  localparam int P1 = 8 * (1 + B);
`else
  localparam int L  = D;
  localparam int P1 = 8;
`endif
  localparam int P = 8 * L;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  frame_t     frame = '0;
  logic       frame_valid = 1'b0;
  logic       frame_ready;
  logic [7:0] row_en, col_data;
  logic       frame_start, swapped;

  logic       frame_ready1;
  logic [7:0] row_en1, col_data1;
  logic       frame_start1, swapped1;

  matrix_scan #(.DWELL(D), .BLANK(B)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame      (frame),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .row_en     (row_en),
    .col_data   (col_data),
    .frame_start(frame_start),
    .swapped    (swapped)
  );

  matrix_scan #(.DWELL(1), .BLANK(B)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .frame      (frame),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready1),
    .row_en     (row_en1),
    .col_data   (col_data1),
    .frame_start(frame_start1),
    .swapped    (swapped1)
  );

  always #5 clk = ~clk;

  int     n_chk = 0;
  int     n_pass = 0;
  int     k = 0;
  bit     full = 1'b0;
  frame_t act = '0;
  frame_t sb[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  tag, got, exp, k);
  endtask

  function automatic int m_row(input int kk);
`ifdef SCAN_BLANK_EN
    return (kk % P) / L;
`else
    return (kk == 0) ? 0 : ((kk - 1) % P) / L;
`endif
  endfunction

  function automatic bit m_drv(input int kk);
`ifdef SCAN_BLANK_EN
    return (kk % L) >= B;
`else
    return kk != 0;
`endif
  endfunction

  function automatic bit m_fs(input int kk);
`ifdef SCAN_BLANK_EN
    return (kk % P) == B;
`else
    return kk != 0 && ((kk - 1) % P) == 0;
`endif
  endfunction

  function automatic bit m_bnd(input int kk);
`ifdef SCAN_BLANK_EN
    return kk > 0 && (kk % P) == 0;
`else
    return kk > 1 && ((kk - 1) % P) == 0;
`endif
  endfunction

  task automatic check_cycle(input bit e_sw);
    int r;
    logic [7:0] e_re, e_col;
    r     = m_row(k);
    e_re  = m_drv(k) ? 8'(1 << r) : 8'h00;
    e_col = m_drv(k) ? act[r*8 +: 8] : 8'h00;
    chk("row_en", row_en, e_re);
    chk("col_data", col_data, e_col);
    chk("frame_start", frame_start, m_fs(k));
    chk("swapped", swapped, e_sw);
    chk("frame_ready", frame_ready, !full);
  endtask

  task automatic tick();
    bit pre, acc, e_sw;
    pre = full;
    acc = frame_valid && !pre;
    @(posedge clk);
    #1;
    k++;
    e_sw = 1'b0;
    if (acc) begin
      sb.push_back(frame);
      full = 1'b1;
    end else if (m_bnd(k) && pre) begin
      act  = sb.pop_front();
      full = 1'b0;
      e_sw = 1'b1;
    end
    check_cycle(e_sw);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_row_en", row_en, 0);
    chk("rst_col_data", col_data, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_swapped", swapped, 0);
    chk("rst_frame_ready", frame_ready, 1);
    sb.delete();
    full = 1'b0;
    act = '0;
    k = 0;
    frame_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_cycle(1'b0);
  endtask

  int         cyc1 = 0;
  int         last_fs1 = -1;
  int         n_fs1 = 0;
  logic [7:0] last_re1 = '0;

  always @(negedge clk) begin
    if (!reset) begin
      cyc1 = 0;
      last_fs1 = -1;
      last_re1 = '0;
    end else begin
      cyc1++;
      if (row_en1 != 8'h00) begin
        if (last_re1 != 8'h00)
          chk("d1_rowseq", row_en1, {last_re1[6:0], last_re1[7]});
        last_re1 = row_en1;
      end
      if (frame_start1) begin
        n_fs1++;
        if (last_fs1 >= 0) chk("d1_period", cyc1 - last_fs1, P1);
        last_fs1 = cyc1;
      end
    end
  end

  frame_t fl[3];
  int     idx;
  bit     will;
  bit     hit;

  initial begin
    do_reset();
    repeat (3) tick();
    frame = 64'h8100_0000_0000_0018;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    frame = '0;
    repeat (2 * P + 4) tick();

    fl[0] = 64'h0102_0408_1020_4080;
    fl[1] = 64'hFF00_FF00_00FF_00FF;
    fl[2] = 64'h1234_5678_9ABC_DEF0;
    idx = 0;
    frame = fl[0];
    frame_valid = 1'b1;
    for (int n = 0; n < 4 * P; n++) begin
      if (idx >= 3) break;
      will = frame_valid && !full;
      tick();
      if (will) begin
        idx++;
        if (idx < 3) frame = fl[idx];
      end
    end
    frame_valid = 1'b0;
    frame = '0;
    chk("stream_sent", idx, 3);
    repeat (2 * P) tick();

    hit = 1'b0;
    for (int n = 0; n < 2 * P; n++) begin
      if (m_drv(k) && m_row(k) == 0) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    chk("reach_row0", hit, 1);
    frame = 64'hA5A5_A5A5_A5A5_A5A5;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    frame = '0;
    hit = 1'b0;
    for (int n = 0; n < 2 * P; n++) begin
      if (m_drv(k) && m_row(k) == 5 && full) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    chk("reach_row5", hit, 1);
    tick();
    do_reset();
    repeat (P + 4) tick();

    chk("d1_fs_seen", n_fs1 >= 2, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/matrix_scan.md
# matrix_scan

Row-multiplexing driver for the 8x8 LED matrix. It accepts a complete 64-bit frame from the game logic through a valid/ready handshake and holds it in a pending buffer. At each frame boundary it swaps the pending frame into an active buffer, so the display never tears. It then scans the active frame one row at a time onto the row-enable and column-data pins. It sits between the snake game core's `matrix` output and the board's LED matrix pins.

## Interface
Parameters:
- `DWELL`, default 1000: clock cycles each row is driven; legal range 1..65535.
- `BLANK`, default 16: clock cycles all rows are off between rows; legal range 1..255. Used only when `SCAN_BLANK_EN` is defined.

Ports:
- `clk`  input  1: system clock.
- `reset`  input  1: asynchronous, active-low reset.
- `frame`  input  64: frame bitmap; bit `r*8+c` is row r, column c (r, c in 0..7).
- `frame_valid`  input  1: `frame` is offered this cycle.
- `frame_ready`  output  1: the pending buffer is empty, so a frame can be accepted.
- `row_en`  output  8: one-hot, active-high row enable; bit r drives row r.
- `col_data`  output  8: column data for the driven row; bit c is column c; 1 = LED on.
- `frame_start`  output  1: one-cycle pulse when row 0 of a new frame begins driving.
- `swapped`  output  1: one-cycle pulse when the pending buffer is copied into the active buffer.

## Operation
- Buffers:
  - `active[63:0]` holds the frame being displayed.
  - `pending[63:0]` holds the next frame, with a flag `pend_full`.
- Handshake:
  - `frame_ready = !pend_full`, combinational.
  - A transfer occurs when `frame_valid && frame_ready` is high at a clock edge. `pending` then loads `frame` and `pend_full` sets.
  - When `frame_ready` is low, `frame_valid` is ignored and nothing is captured.
- States:
  - BLANK: `row_en = 0`, `col_data = 0`, count `BLANK` cycles.
  - DRIVE: `row_en = 1 << row`, `col_data = active[row*8 +: 8]`, count `DWELL` cycles.
- Transitions:
  - BLANK -> DRIVE after the `BLANK` count expires.
  - DRIVE -> BLANK after the `DWELL` count expires; `row` increments and wraps from 7 to 0.
- Frame boundary: the cycle DRIVE of row 7 expires.
  - If `pend_full` is set: `active <= pending`, `pend_full` clears, and `swapped` pulses on the following cycle.
  - If `pend_full` is clear: `active` is retained and `swapped` does not pulse.
- Simultaneous events:
  - A `frame_valid` in the swap cycle is not accepted, because `frame_ready` is still low.
  - `frame_ready` rises on the next cycle.
- Dwell counter: 16 bits. Blank counter: 8 bits. Row counter: 3 bits, wraps naturally.
- Reset, asynchronous and valid at any time, including mid-row:
  - Register values: state = BLANK, `row` = 0, counters = 0, `active` = 0, `pending` = 0, `pend_full` = 0.
  - Output values: `row_en` = 0, `col_data` = 0, `frame_ready` = 1, `frame_start` = 0, `swapped` = 0.
- Outputs are registered, except `frame_ready`. `row_en` and `col_data` change on the same edge, so no glitch combination of old row and new data appears.

## Timing
- Frame period, with `SCAN_BLANK_EN`: `8*(DWELL+BLANK)` cycles.
- Frame period, without it: `8*DWELL` cycles.
- First light after reset release: row 0 drives at cycle `BLANK` (or cycle 1 without the macro), with `frame_start` high in that cycle.
- Accept-to-display latency: a frame accepted mid-frame appears at the next row-0 DRIVE.
- A frame accepted exactly at the boundary cycle is impossible, because `frame_ready` is low then.
- `frame_start` is asserted for exactly one cycle, coincident with the first DRIVE cycle of row 0.
- `swapped` is asserted for exactly one cycle, one cycle after the row-7 expiry edge.

## Configuration
- Macro: `SCAN_BLANK_EN`.
- Defined: the BLANK state is inserted before every row, with `BLANK` cycles of dead time for anti-ghosting.
- Undefined: there is no BLANK state. DRIVE of row r is followed directly by DRIVE of row r+1. The `BLANK` parameter is unused, and the reset state is DRIVE row 0 with `row_en` = 0 for one cycle.

## Structure
- Shared package `snake_pkg` holds:
  - `ROWS = 8`, `COLS = 8`;
  - `frame_t` (`logic [63:0]`);
  - scan state enum `{ST_BLANK, ST_DRIVE}`;
  - a helper function for the bit index `r*COLS+c`. The game core uses the same mapping.
- One natural sub-module, `frame_buffer`, holds the pending and active registers, the handshake and the swap logic. The scan FSM stays in `matrix_scan`.

## Test plan
Benches use `DWELL=4`, `BLANK=2` unless stated otherwise.
- Reset, then no frame -> `row_en` cycles 01, 02, ..., 80 in order, each for 4 cycles with 2 zero cycles between. `col_data` = 00 throughout. `frame_ready` = 1.
- Send `frame = 64'h8100_0000_0000_0018` in cycle 3 -> `frame_ready` goes low from cycle 4. After the row-7 expiry: `swapped` pulses, then at row 0 `col_data` = 18, at row 7 `col_data` = 81, and all other rows are 00.
- Hold `frame_valid` high continuously with frames A, B, C -> exactly one frame is accepted per frame period. `frame_ready` is low in the swap cycle and high the following cycle.
- Assert `reset` low mid-DRIVE of row 5 with a pending frame -> all outputs are 0 immediately (asynchronous). After release, `pending` is discarded and the scan restarts at row 0.
- Compile without `SCAN_BLANK_EN` -> there are no zero cycles between rows, the frame period is 32 cycles, and `frame_start` pulses every 32 cycles.
- `DWELL=1` -> each row is driven for a single cycle and the row-7 to row-0 wrap is correct. `frame_start` pulses every 24 cycles with `SCAN_BLANK_EN` (8 rows x (1 + 2)).
